alu_pipe_flags: RTL and testbench

//  Parametrised, registered ARM data-processing ALU with an internal NZCV

---
 rtl/alu_pipe_flags_if.sv | 10 +
 rtl/alu_pipe_flags.sv | 132 +++++++++++++
 tb/tb_alu_pipe_flags.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_flags_if.sv
// alu_pipe_flags_if: request/response bundle between operand fetch, the ALU and writeback.
interface alu_pipe_flags_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, s, mul, flags_ld, out_valid, out_ready, result_we;
  logic [3:0] op, flags_in, flags;
  logic [WIDTH-1:0] a, b, result;
  modport master(output in_valid, op, s, a, b, mul, flags_ld, flags_in, out_ready,
                 input in_ready, out_valid, result, result_we, flags);
  modport slave(input in_valid, op, s, a, b, mul, flags_ld, flags_in, out_ready,
                output in_ready, out_valid, result, result_we, flags);
endinterface

// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: registered ARM data-processing ALU with NZCV register and valid/ready handshakes.
// Define ALU_MUL_EN to build the iterative shift-add multiplier.
module alu_pipe_flags #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  alu_pipe_flags_if.slave io
);
  logic [WIDTH-1:0] result_q, result_d, x, y, yv, r, prod_fin;
  logic [WIDTH:0] sum;
  logic [3:0] flags_q, flags_d, nf;
  logic out_valid_q, out_valid_d, we_q, we_d;
  logic arith, sub, swap, cin, cmp, slot_free, accept, mul_go, done, mul_s;
  assign slot_free = !out_valid_q || io.out_ready;
  assign accept = io.in_valid && io.in_ready;
`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic ms_q, ms_d, last;
  assign io.in_ready = state_q == IDLE && slot_free;
  assign mul_go = io.mul;
  assign mul_s = ms_q;
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  assign prod_fin = prod_q + (mplier_q[0] ? mcand_q : '0);
  // The last partial product is folded in on the completion edge, so a stalled slot just holds here.
  assign done = state_q == MUL_BUSY && last && slot_free;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    prod_d = prod_q;
    ms_d = ms_q;
    if (accept && io.mul) begin
      state_d = MUL_BUSY;
      cnt_d = '0;
      mcand_d = io.a;
      mplier_d = io.b;
      prod_d = '0;
      ms_d = io.s;
    end else if (state_q == MUL_BUSY && !last) begin
      cnt_d = cnt_q + 1'b1;
      prod_d = prod_fin;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      prod_q <= '0;
      ms_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      ms_q <= ms_d;
    end
  end
`else
  assign io.in_ready = slot_free;
  assign mul_go = 1'b0;
  assign mul_s = 1'b0;
  assign done = 1'b0;
  assign prod_fin = '0;
`endif
  always_comb begin
    swap = io.op == 4'h3 || io.op == 4'h7;
    sub = io.op inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA};
    arith = sub || io.op inside {4'h4, 4'h5, 4'hB};
    cin = io.op inside {4'h5, 4'h6, 4'h7} ? flags_q[1] : sub;
    x = swap ? io.b : io.a;
    y = swap ? io.a : io.b;
    yv = sub ? ~y : y;
    // Subtraction as x + ~y + cin, so the carry-out is directly NOT borrow.
    sum = {1'b0, x} + {1'b0, yv} + (WIDTH+1)'(cin);
    case (io.op)
      4'h0, 4'h8: r = io.a & io.b;
      4'h1, 4'h9: r = io.a ^ io.b;
      4'hC: r = io.a | io.b;
      4'hD: r = io.b;
      4'hE: r = io.a & ~io.b;
      4'hF: r = ~io.b;
      default: r = sum[WIDTH-1:0];
    endcase
    cmp = io.op[3:2] == 2'b10;
    nf = {r[WIDTH-1], r == '0, arith ? sum[WIDTH] : flags_q[1],
          arith ? (x[WIDTH-1] == yv[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]) : flags_q[0]};
    out_valid_d = out_valid_q && !io.out_ready;
    result_d = result_q;
    we_d = we_q;
    flags_d = io.flags_ld ? io.flags_in : flags_q;
    if (accept && !mul_go) begin
      out_valid_d = 1'b1;
      result_d = r;
      we_d = !cmp;
      if (io.s || cmp) flags_d = nf;
    end
    if (done) begin
      out_valid_d = 1'b1;
      result_d = prod_fin;
      we_d = 1'b1;
      if (mul_s) flags_d = {prod_fin[WIDTH-1], prod_fin == '0, flags_q[1:0]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      we_q <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      we_q <= we_d;
      flags_q <= flags_d;
    end
  end
  assign io.out_valid = out_valid_q;
  assign io.result = result_q;
  assign io.result_we = we_q;
  assign io.flags = flags_q;
endmodule

// File: tb/tb_alu_pipe_flags.sv
// tb_alu_pipe_flags: randomized scoreboard bench for alu_pipe_flags against an arithmetic reference model.
module tb_alu_pipe_flags;
  typedef struct {logic [31:0] r; logic we;} exp_t;
  logic clk = 0, rst_n = 0;
  int tests = 0, fails = 0;
  exp_t m_q[$];
  logic m_pend = 0, m_busy = 0, m_ms = 0;
  logic [3:0] m_flags = 0;
  logic [31:0] m_prod = 0;
  int m_steps = 0;
  alu_pipe_flags_if #(.WIDTH(32)) io();
  alu_pipe_flags #(.WIDTH(32)) dut(.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Reference: exact integer arithmetic, carry = unsigned overflow/no-borrow, V = signed range overflow.
  task automatic alu_model(input logic [3:0] op, input logic s, input logic [31:0] a, b, input logic [3:0] f,
                           output logic [31:0] r, output logic [3:0] nf, output logic we, output logic upd);
    longint ux, uy, sx, sy, u, sv;
    logic is_sub, arith, c, v;
    int k;
    arith = 1;
    is_sub = op inside {2, 3, 6, 7, 10};
    k = op == 5 ? int'(f[1]) : (op == 6 || op == 7) ? int'(!f[1]) : 0;
    ux = (op == 3 || op == 7) ? longint'({32'h0, b}) : longint'({32'h0, a});
    uy = (op == 3 || op == 7) ? longint'({32'h0, a}) : longint'({32'h0, b});
    sx = (op == 3 || op == 7) ? longint'(signed'(b)) : longint'(signed'(a));
    sy = (op == 3 || op == 7) ? longint'(signed'(a)) : longint'(signed'(b));
    u = is_sub ? ux - uy - k : ux + uy + k;
    sv = is_sub ? sx - sy - k : sx + sy + k;
    c = is_sub ? (ux >= uy + k) : (u >= 64'sh1_0000_0000);
    v = sv > 64'sh7FFF_FFFF || sv < -64'sh8000_0000;
    r = u[31:0];
    case (op)
      0, 8: begin r = a & b; arith = 0; end
      1, 9: begin r = a ^ b; arith = 0; end
      12: begin r = a | b; arith = 0; end
      13: begin r = b; arith = 0; end
      14: begin r = a & ~b; arith = 0; end
      15: begin r = ~b; arith = 0; end
      default: ;
    endcase
    we = !(op inside {8, 9, 10, 11});
    upd = s || !we;
    nf = {r[31], r == 0, arith ? c : f[1], arith ? v : f[0]};
  endtask

  task automatic cyc(input logic iv, input logic [3:0] op, input logic s, input logic [31:0] a, b,
                     input logic mul, fld, input logic [3:0] fin, input logic ordy);
    logic exp_rdy, acc, pend0, done, we, upd, do_mul;
    logic [31:0] r;
    logic [3:0] nf;
    @(negedge clk);
    #1;
    io.in_valid = iv; io.op = op; io.s = s; io.a = a; io.b = b; io.mul = mul;
    io.flags_ld = fld; io.flags_in = fin; io.out_ready = ordy;
    exp_rdy = !m_busy && (!m_pend || ordy);
    #1 chk("in_ready", io.in_ready, exp_rdy);
    acc = iv && exp_rdy;
    done = 0;
`ifdef ALU_MUL_EN
    do_mul = mul;
`else
    do_mul = 0;
`endif
    @(posedge clk);
    pend0 = m_pend;
    if (m_pend && ordy) m_pend = 0;
    if (m_busy) begin
      if (m_steps < 31) m_steps++;
      else if (!pend0 || ordy) begin
        done = 1; m_busy = 0; m_pend = 1;
        m_q.push_back('{m_prod, 1'b1});
        if (m_ms) m_flags[3:2] = {m_prod[31], m_prod == 0};
      end
    end
    if (acc && do_mul) begin
      m_busy = 1; m_steps = 0; m_prod = a * b; m_ms = s;
      if (fld) m_flags = fin;
    end else if (acc) begin
      alu_model(op, s, a, b, m_flags, r, nf, we, upd);
      m_q.push_back('{r, we});
      m_pend = 1;
      if (upd) m_flags = nf;
      else if (fld) m_flags = fin;
    end else if (!(done && m_ms) && fld) m_flags = fin;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 0; io.in_valid = 0; io.flags_ld = 0; io.mul = 0;
    m_pend = 0; m_busy = 0; m_flags = 0; m_q.delete();
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_result", io.result, 0);
    chk("rst_result_we", io.result_we, 0);
    chk("rst_flags", io.flags, 0);
    chk("rst_in_ready", io.in_ready, 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    chk("out_valid", io.out_valid, m_pend);
    chk("flags", io.flags, m_flags);
    if (io.out_valid && io.out_ready) begin
      if (m_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = m_q.pop_front();
        chk("result", io.result, e.r);
        chk("result_we", io.result_we, e.we);
      end
    end
  end

  initial begin
    io.in_valid = 0; io.op = 0; io.s = 0; io.a = 0; io.b = 0; io.mul = 0;
    io.flags_ld = 0; io.flags_in = 0; io.out_ready = 1;
    do_reset();
    idle(1);
    cyc(1, 4'h4, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
    #1 chk("t1_result", io.result, 0); chk("t1_we", io.result_we, 1); chk("t1_flags", io.flags, 4'b0110);
    cyc(1, 4'h2, 1, 32'h8000_0000, 1, 0, 0, 0, 1);
    #1 chk("t2_result", io.result, 32'h7FFF_FFFF); chk("t2_flags", io.flags, 4'b0011);
    cyc(1, 4'hA, 0, 5, 5, 0, 0, 0, 1);
    #1 chk("t3_cmp_we", io.result_we, 0); chk("t3_flags", io.flags, 4'b0110);
    cyc(1, 4'h5, 0, 1, 2, 0, 0, 0, 1);
    #1 chk("t3_adc", io.result, 4);
    cyc(1, 4'h4, 0, 2, 3, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'h4, 0, 9, 9, 0, 0, 0, 0);
      #1 chk("t4_hold_result", io.result, 5); chk("t4_hold_valid", io.out_valid, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 4'h4, 1, 1, 1, 0, 1, 4'hF, 1);
    #1 chk("t5_flags", io.flags, 4'b0000); chk("t5_result", io.result, 2);
`ifdef ALU_MUL_EN
    cyc(1, 0, 0, 7, 6, 1, 0, 0, 1);
    idle(32);
    #1 chk("t6_mul_valid", io.out_valid, 1); chk("t6_mul_result", io.result, 32'h2A);
    cyc(1, 0, 1, 7, 6, 1, 0, 0, 1);
    idle(9);
    do_reset();
    idle(40);
`endif
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset();
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pick(), pick(),
          $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 100 && (m_pend || m_busy); i++) idle(1);
    idle(1);
    chk("drained", m_pend || m_busy, 0);
    chk("queue_empty", m_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
